// File: rtl/rom_burst_reader.sv
// Parametrised ROM, mem[i] = 3*i+1, read out as ascending or descending wrap-around
// bursts on a valid/ready stream with backpressure and abort.
module rom_burst_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] add,
  input  logic [LEN_W-1:0]  len,
  input  logic              dir,
  input  logic              abort,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int unsigned TW = DATA_W + ADDR_W + 2;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_ptr, w_ptr_nxt;
  logic [LEN_W-1:0]   r_rem, w_rem_nxt;
  logic               r_dir, w_dir_nxt;
  logic [DATA_W-1:0]  r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_last, w_last_nxt;
  logic               w_free;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [TW-1:0] t;
    t = TW'(a) * TW'(3) + TW'(1);
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] p, input logic d);
    return d ? (p - 1'b1) : (p + 1'b1);
  endfunction

  assign w_free = !r_valid || data_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_data_nxt  = rom_word(add);
          w_valid_nxt = 1'b1;
          w_last_nxt  = (len == '0);
          w_ptr_nxt   = step(add, dir);
          w_rem_nxt   = len;
          w_dir_nxt   = dir;
          w_state_nxt = (len == '0) ? DRAIN : RUN;
        end else if (r_valid && data_ready) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
      end
      RUN: begin
        // RUN always has r_rem >= 1; the beat issued at r_rem==1 is the last one.
        if (w_free) begin
          w_data_nxt  = rom_word(r_ptr);
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = step(r_ptr, r_dir);
          w_rem_nxt   = r_rem - 1'b1;
          w_last_nxt  = (r_rem == LEN_W'(1));
          if (r_rem == LEN_W'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (data_ready) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
      r_dir   <= w_dir_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign data_last  = r_last;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader: expected beats queued at start, popped on transfer.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] add;
  logic [3:0] len;
  logic       dir;
  logic       abort;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_last;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [8:0]  exp_q[$];
  logic        hold_pending = 1'b0;
  logic [7:0]  hold_data;

  rom_burst_reader #(.DATA_W(8), .ADDR_W(3), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .add(add), .len(len), .dir(dir),
    .abort(abort), .data_ready(data_ready), .data_out(data_out),
    .data_valid(data_valid), .data_last(data_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [7:0] rom_model(input int unsigned i);
    return 8'((3 * i + 1) % 256);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [2:0] a, input logic [3:0] l, input logic d);
    logic [2:0] p;
    p = a;
    for (int unsigned i = 0; i <= l; i++) begin
      exp_q.push_back({(i == l), rom_model(p)});
      p = d ? p - 3'd1 : p + 3'd1;
    end
    start = 1'b1; add = a; len = l; dir = d;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick;
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", {31'd0, data_valid}, 32'd1);
        check("hold_data", {24'd0, data_out}, {24'd0, hold_data});
      end
      if (data_valid && data_ready) begin
        check("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("beat_data", {24'd0, data_out}, {24'd0, e[7:0]});
          check("beat_last", {31'd0, data_last}, {31'd0, e[8]});
        end
      end
      hold_pending <= data_valid && !data_ready && !abort;
      hold_data    <= data_out;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; add = '0; len = '0; dir = 1'b0; abort = 1'b0; data_ready = 1'b1;
    repeat (2) tick;
    start = 1'b1; add = 3'd4; len = 4'd2;
    repeat (2) tick;
    start = 1'b0;
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_last", {31'd0, data_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // descending: 22,19,16,13, busy falls the cycle after the last beat
    start_burst(3'd7, 4'd3, 1'b1);
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("lat_valid", {31'd0, data_valid}, 32'd1);
    repeat (3) tick;
    check("busy_drain", {31'd0, busy}, 32'd1);
    tick;
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("desc_done", exp_q.size(), 32'd0);

    start_burst(3'd6, 4'd3, 1'b0);
    wait_idle(20);
    start_burst(3'd1, 4'd2, 1'b1);
    wait_idle(20);

    // backpressure after first beat
    data_ready = 1'b0;
    start_burst(3'd2, 4'd2, 1'b0);
    repeat (3) tick;
    check("bp_data", {24'd0, data_out}, 32'd7);
    data_ready = 1'b1;
    wait_idle(20);

    // single beat, start while busy ignored, start on first idle cycle accepted
    start_burst(3'd5, 4'd0, 1'b0);
    check("single_last", {31'd0, data_last}, 32'd1);
    start = 1'b1; add = 3'd0; len = 4'd5; dir = 1'b0;
    tick;
    start = 1'b0;
    check("single_idle", {31'd0, busy}, 32'd0);
    start_burst(3'd1, 4'd0, 1'b0);
    wait_idle(20);

    // abort after the second beat
    start_burst(3'd0, 4'd7, 1'b0);
    repeat (2) tick;
    abort = 1'b1; data_ready = 1'b0;
    tick;
    abort = 1'b0;
    check("abort_valid", {31'd0, data_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_left", exp_q.size(), 32'd6);
    exp_q.delete();
    data_ready = 1'b1;
    start_burst(3'd3, 4'd0, 1'b0);
    wait_idle(20);

    // random bursts with random ready and input churn while busy
    for (int k = 0; k < 8; k++) begin
      int unsigned n;
      data_ready = 1'b1;
      start_burst(3'($urandom), 4'($urandom), 1'($urandom));
      n = 0;
      while (busy && n < 200) begin
        data_ready = 1'($urandom);
        start = 1'($urandom); add = 3'($urandom); len = 4'($urandom); dir = 1'($urandom);
        tick;
        n++;
      end
      start = 1'b0; data_ready = 1'b1;
      check("rand_done", exp_q.size(), 32'd0);
      wait_idle(20);
    end

    // asynchronous reset mid-burst
    start_burst(3'd0, 4'd7, 1'b0);
    tick;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, data_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_data", {24'd0, data_out}, 32'd0);
    exp_q.delete();
    tick;
    rst = 1'b0;
    start_burst(3'd3, 4'd0, 1'b0);
    check("post_rst_valid", {31'd0, data_valid}, 32'd1);
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
